// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder with programmable wait states
// Optional alignment checking is enabled by defining MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rd_q, rd_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            enter_resp;
  logic            acc_we;
  logic            acc_bad;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic            mem_we;
  logic            req_bad;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic            bad_q, bad_d;
  logic            resp_err_q, resp_err_d;
  logic            unused_addr_hi;
  assign req_bad        = |req_addr[1:0];
  assign unused_addr_hi = ^req_addr[31:AW+2];
  assign resp_err       = resp_err_q;
`else
  logic            unused_addr_bits;
  assign req_bad          = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign resp_err         = 1'b0;
`endif

  // With zero wait states the memory access happens on the acceptance edge, so
  // the access fields come straight from the request port while in IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_idx   = req_addr[AW+1:2];
      acc_wdata = req_wdata;
      acc_bad   = req_bad;
    end else begin
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      acc_bad   = bad_q;
`else
      acc_bad   = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    enter_resp   = 1'b0;
    req_ready    = (state_q == IDLE);
    busy         = (state_q != IDLE);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    bad_d        = bad_q;
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
          bad_d   = req_bad;
`endif
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = rd_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        resp_err_d   = bad_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rd_d = (acc_we || acc_bad) ? 32'd0 : mem[acc_idx];
    end
  end

  assign mem_we     = enter_resp && acc_we && !acc_bad;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      rd_q         <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      bad_q        <= 1'b0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      bad_q        <= bad_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  // Memory is never cleared; reset held at the edge blocks any write.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (WAIT_CYCLES=2 and 0 instances)
module tb_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_valid, a_we, a_ready, a_rv, a_err, a_busy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_we, b_ready, b_rv, b_err, b_busy;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int a_resps  = 0;
  int b_resps  = 0;
  logic [32:0] a_q[$];
  logic [32:0] b_q[$];

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_ready(a_ready), .resp_valid(a_rv), .resp_rdata(a_rdata),
    .resp_err(a_err), .busy(a_busy));

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_ready(b_ready), .resp_valid(b_rv), .resp_rdata(b_rdata),
    .resp_err(b_err), .busy(b_busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (a_rv === 1'b1) begin
      a_resps++;
      check("a_resp_expected", {31'b0, a_q.size() != 0}, 32'd1);
      if (a_q.size() != 0) begin
        e = a_q.pop_front();
        check("a_rdata", a_rdata, e[31:0]);
        check("a_err", {31'b0, a_err}, {31'b0, e[32]});
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (b_rv === 1'b1) begin
      b_resps++;
      check("b_resp_expected", {31'b0, b_q.size() != 0}, 32'd1);
      if (b_q.size() != 0) begin
        e = b_q.pop_front();
        check("b_rdata", b_rdata, e[31:0]);
        check("b_err", {31'b0, b_err}, {31'b0, e[32]});
      end
    end
  end

  task automatic a_do(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [32:0] exp);
    int start;
    int cnt;
    @(negedge clk);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    a_q.push_back(exp);
    start = a_resps;
    @(posedge clk); #1 a_valid = 1'b0;
    cnt = 0;
    while (a_resps == start && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("a_resp_timeout", {31'b0, cnt < 50}, 32'd1);
  endtask

  task automatic b_do(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [32:0] exp);
    int start;
    int cnt;
    @(negedge clk);
    b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    b_q.push_back(exp);
    start = b_resps;
    @(posedge clk); #1 b_valid = 1'b0;
    cnt = 0;
    while (b_resps == start && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("b_resp_timeout", {31'b0, cnt < 50}, 32'd1);
  endtask

  initial begin
    int s;
    logic [32:0] exp_al;
    logic [31:0] exp_20;
    reset = 1'b1;
    a_valid = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_a_ready", {31'b0, a_ready}, 32'd1);
    check("rst_a_rv",    {31'b0, a_rv},    32'd0);
    check("rst_a_rdata", a_rdata,          32'd0);
    check("rst_a_err",   {31'b0, a_err},   32'd0);
    check("rst_a_busy",  {31'b0, a_busy},  32'd0);
    check("rst_b_ready", {31'b0, b_ready}, 32'd1);
    check("rst_b_rv",    {31'b0, b_rv},    32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Timed write: response only in the cycle after edge T+3
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
    a_q.push_back({1'b0, 32'h0});
    @(posedge clk); #1 a_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("a_lat_rv_%0d", k), {31'b0, a_rv}, {31'b0, k == 3});
      if (k < 3) check($sformatf("a_lat_busy_%0d", k), {31'b0, a_busy}, 32'd1);
      if (k < 3) check($sformatf("a_lat_ready_%0d", k), {31'b0, a_ready}, 32'd0);
    end
    a_do(1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF});

    // Wrap-around
    a_do(1'b1, 32'h400, 32'h12345678, {1'b0, 32'h0});
    a_do(1'b0, 32'h0, 32'h0, {1'b0, 32'h12345678});

    a_do(1'b1, 32'h20, 32'hCAFEF00D, {1'b0, 32'h0});

    // Request pulsed during WAIT is ignored
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'h11111111;
    a_q.push_back({1'b0, 32'h0});
    s = a_resps;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    check("a_wait_ready", {31'b0, a_ready}, 32'd0);
    a_valid = 1'b1; a_wdata = 32'h22222222;
    @(posedge clk); #1 a_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("a_ignored_one_resp", a_resps - s, 32'd1);
    a_do(1'b0, 32'h30, 32'h0, {1'b0, 32'h11111111});

    // Reset during WAIT drops the pending write
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h5A5A5A5A;
    s = a_resps;
    @(posedge clk); #1 a_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("a_midrst_ready", {31'b0, a_ready}, 32'd1);
    check("a_midrst_busy",  {31'b0, a_busy},  32'd0);
    check("a_midrst_rv",    {31'b0, a_rv},    32'd0);
    check("a_midrst_rdata", a_rdata,          32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("a_midrst_no_resp", a_resps - s, 32'd0);
    a_do(1'b0, 32'h20, 32'h0, {1'b0, 32'hCAFEF00D});

    // Misaligned write
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    exp_al = {1'b1, 32'h0};
    exp_20 = 32'hCAFEF00D;
`else
    exp_al = {1'b0, 32'h0};
    exp_20 = 32'hAAAA5555;
`endif
    a_do(1'b1, 32'h22, 32'hAAAA5555, exp_al);
    a_do(1'b0, 32'h20, 32'h0, {1'b0, exp_20});

    // Zero wait states: back-to-back reads with req_valid held high
    b_do(1'b1, 32'h0, 32'hA0A0A0A0, {1'b0, 32'h0});
    b_do(1'b1, 32'h4, 32'hB4B4B4B4, {1'b0, 32'h0});
    @(negedge clk);
    s = b_resps;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    check("b_rdy_0", {31'b0, b_ready}, 32'd1);
    b_q.push_back({1'b0, 32'hA0A0A0A0});
    @(negedge clk);
    check("b_rdy_1", {31'b0, b_ready}, 32'd0);
    check("b_rv_1",  {31'b0, b_rv},    32'd0);
    b_addr = 32'h4;
    b_q.push_back({1'b0, 32'hB4B4B4B4});
    @(negedge clk);
    check("b_rdy_2", {31'b0, b_ready}, 32'd1);
    check("b_rv_2",  {31'b0, b_rv},    32'd1);
    @(negedge clk);
    check("b_rdy_3", {31'b0, b_ready}, 32'd0);
    check("b_rv_3",  {31'b0, b_rv},    32'd0);
    b_valid = 1'b0;
    @(negedge clk);
    check("b_rv_4",  {31'b0, b_rv},    32'd1);
    repeat (3) @(negedge clk);
    check("b_b2b_resps", b_resps - s, 32'd2);
    check("a_queue_empty", a_q.size(), 32'd0);
    check("b_queue_empty", b_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder serving the multicycle CPU's memory port: the slave end of the fetch, load and store requests the control unit sequences through IorD, MemWrite and IRWrite. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states and returns read data or a write acknowledgement with a one-cycle response pulse. It sits between the datapath's address/write-data mux outputs and the instruction/data register load enables.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, minimum 4.
- WAIT_CYCLES, 2: wait states between acceptance and response; 0 to 15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  read data, valid with resp_valid.
- resp_err  out  1  error flag, valid with resp_valid.
- busy  out  1  a request is in flight.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1, busy=0. If req_valid=1 at a clock edge, the responder latches req_we, req_addr and req_wdata and loads the wait counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT: req_ready=0, busy=1. The counter decrements each cycle. On the edge where the counter is 1, the FSM goes to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - For a write, the memory is updated on the edge that enters RESP.
  - For a read, resp_rdata holds the word at the latched address, sampled on the edge that enters RESP.
  - For a write, resp_rdata=0.
- Word index is req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4 bytes.
- Backpressure on the response is not supported. The requester must be ready for resp_valid.
- While req_ready=0, req_valid is ignored. Requests arriving during WAIT or RESP are not queued.
- Memory contents are not cleared by reset and are undefined after power-up.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, counter=0.
- Latency: a request accepted at edge T produces resp_valid high in the cycle after edge T+1+WAIT_CYCLES. With WAIT_CYCLES=0 this is the cycle after edge T+1.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- req_ready is combinational from state only, never from req_valid.
- Reset asserted mid-operation: return to IDLE immediately.
  - A pending write is dropped if reset arrives before the RESP-entry edge.
  - Memory is otherwise untouched and no response is issued.
- resp_rdata and resp_err hold their last value outside resp_valid, until the next response.

## Configuration
- MEM_RESPONDER_ALIGN_CHECK_EN defined:
  - A request with req_addr[1:0]!=0 is accepted and takes the normal latency.
  - The write is suppressed, resp_rdata=0 and resp_err=1 in RESP.
  - Aligned requests give resp_err=0.
- Macro undefined: req_addr[1:0] is ignored, resp_err is tied to 0 and no alignment logic is generated.

## Test plan
- Reset released, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 accepted at edge T -> resp_valid high only in the cycle after edge T+3, resp_rdata=0. Read of 0x10 -> resp_rdata=0xDEADBEEF.
- WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 with req_valid held high -> req_ready pattern 1,0,1,0; responses one cycle apart as specified; correct data each time.
- DEPTH_WORDS=256: write 0x12345678 to 0x400 -> read of 0x0 returns 0x12345678 (wrap-around).
- req_valid pulsed during WAIT -> ignored. Exactly one response; memory unchanged by the ignored request.
- Write to 0x20 with reset asserted in WAIT -> outputs return to reset values immediately, no resp_valid, and a later read of 0x20 returns the prior contents.
- With MEM_RESPONDER_ALIGN_CHECK_EN: write 0xAAAA5555 to 0x22 -> resp_err=1, rdata=0. A read of 0x20 is unchanged. Without the macro the same write lands at word 0x20 and resp_err=0.
